// File: rtl/pipe_pkg.sv
// Shared sizing helpers and default dimensions for the pipeline buffer blocks.
package pipe_pkg;
   localparam int PIPE_DATA_WIDTH = 32;
   localparam int PIPE_DEPTH      = 2;

   // Pointer width, never narrower than one bit so DEPTH=1 still has a pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/elastic_buffer_mem.sv
// Storage for the elastic buffer: one write port, one asynchronous read port, no reset.
module elastic_buffer_mem
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
   parameter int DEPTH      = PIPE_DEPTH
) (
   input  logic                         clk,
   input  logic                         i_wr_en,
   input  logic [ptr_width(DEPTH)-1:0]  i_wr_addr,
   input  logic [DATA_WIDTH-1:0]        i_wr_data,
   input  logic [ptr_width(DEPTH)-1:0]  i_rd_addr,
   output logic [DATA_WIDTH-1:0]        o_rd_data
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/elastic_buffer.sv
// Valid/ready elastic FIFO: pointer/count control here, storage in elastic_buffer_mem.
module elastic_buffer
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
   parameter int DEPTH      = PIPE_DEPTH,
   parameter int PASS_READY = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [cnt_width(DEPTH)-1:0]  count
);
   localparam int PW = ptr_width(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_not_full, w_push, w_pop;
   logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

   assign w_not_full = (r_count < CW'(DEPTH));
   // Flush masks both handshakes so nothing moves in the discard cycle.
   assign in_ready  = (w_not_full || ((PASS_READY != 0) && out_ready)) && !flush;
   assign out_valid = (r_count != '0) && !flush;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
   assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
         if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign count = r_count;

   elastic_buffer_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk        (clk),
      .i_wr_en    (w_push),
      .i_wr_addr  (r_wr_ptr),
      .i_wr_data  (in_data),
      .i_rd_addr  (r_rd_ptr),
      .o_rd_data  (out_data)
   );
endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: nine parameter sets side by side, vector table, corner sequences, queue-model random run.
module tb_elastic_buffer;
   localparam int NC = 9;

   function automatic int cfg_depth(input int i);
      case (i)
         0, 4:    return 1;
         1, 5:    return 2;
         2, 6:    return 3;
         3, 7:    return 5;
         default: return 4;
      endcase
   endfunction

   function automatic int cfg_pass(input int i);
      return (i >= 4 && i <= 7) ? 1 : 0;
   endfunction

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NC-1:0]           flush = '0;
   logic [NC-1:0]           in_valid = '0;
   logic [NC-1:0]           out_ready = '0;
   logic [NC-1:0][31:0]     in_data = '0;
   logic [NC-1:0]           in_ready;
   logic [NC-1:0]           out_valid;
   logic [NC-1:0][31:0]     out_data;
   logic [NC-1:0][3:0]      cnt;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NC; g++) begin : g_dut
      localparam int D  = cfg_depth(g);
      localparam int P  = cfg_pass(g);
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] w_cnt;
      logic [31:0]   w_od;
      logic          w_ir, w_ov;

      elastic_buffer #(.DATA_WIDTH(32), .DEPTH(D), .PASS_READY(P)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush[g]),
         .in_data   (in_data[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (w_ir),
         .out_data  (w_od),
         .out_valid (w_ov),
         .out_ready (out_ready[g]),
         .count     (w_cnt)
      );
      assign in_ready[g]  = w_ir;
      assign out_valid[g] = w_ov;
      assign out_data[g]  = w_od;
      assign cnt[g]       = 4'(w_cnt);
   end

   task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s cfg%0d: got 0x%08h expected 0x%08h at %0t", nm, c, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        e_ir;
      logic        e_ov;
      logic        chk_d;
      logic [31:0] e_d;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tv [11];
   logic [31:0] mq [NC][$];
   logic [31:0] prev_head [NC];
   bit          prev_stall [NC];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, got, pushes, pops;

      // DEPTH=2, PASS_READY=0 vector table (config 1), applied from reset.
      tv[0]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
      tv[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 4'd1};
      tv[2]  = '{1'b0, 1'b1, 32'h2,         1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 4'd1};
      tv[3]  = '{1'b0, 1'b1, 32'h3,         1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 4'd2};
      tv[4]  = '{1'b0, 1'b1, 32'h3,         1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 4'd2};
      tv[5]  = '{1'b0, 1'b1, 32'h3,         1'b1, 1'b1, 1'b1, 1'b1, 32'h2,         4'd1};
      tv[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         4'd1};
      tv[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
      tv[8]  = '{1'b0, 1'b1, 32'h55,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};
      tv[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h55,        4'd1};
      tv[10] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         4'd0};

      // Reset state on every configuration.
      #12;
      for (int c = 0; c < NC; c++) begin
         chk("rst_in_ready", c, 32'(in_ready[c]), 32'd1);
         chk("rst_out_valid", c, 32'(out_valid[c]), 32'd0);
         chk("rst_count", c, 32'(cnt[c]), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 11; v++) begin
         flush[1] = tv[v].fl; in_valid[1] = tv[v].iv; in_data[1] = tv[v].d; out_ready[1] = tv[v].ordy;
         #1;
         chk($sformatf("tv%0d_in_ready", v), 1, 32'(in_ready[1]), 32'(tv[v].e_ir));
         chk($sformatf("tv%0d_out_valid", v), 1, 32'(out_valid[1]), 32'(tv[v].e_ov));
         chk($sformatf("tv%0d_count", v), 1, 32'(cnt[1]), 32'(tv[v].e_cnt));
         if (tv[v].chk_d) chk($sformatf("tv%0d_out_data", v), 1, out_data[1], tv[v].e_d);
         @(negedge clk);
      end
      flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b0;

      // Asynchronous reset with two entries held, then first post-reset push pops first.
      in_valid[1] = 1'b1; in_data[1] = 32'h11;
      @(negedge clk); in_data[1] = 32'h22;
      @(negedge clk); in_valid[1] = 1'b0;
      #1;
      chk("pre_arst_count", 1, 32'(cnt[1]), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 1, 32'(out_valid[1]), 32'd0);
      chk("arst_count", 1, 32'(cnt[1]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid[1] = 1'b1; in_data[1] = 32'h77;
      @(negedge clk); in_valid[1] = 1'b0;
      #1;
      chk("post_rst_first", 1, out_data[1], 32'h77);
      chk("post_rst_count", 1, 32'(cnt[1]), 32'd1);
      out_ready[1] = 1'b1;
      @(negedge clk); out_ready[1] = 1'b0;

      // DEPTH=4 fills with five offered words, then drains in order.
      acc = 0;
      for (int k = 1; k <= 5; k++) begin
         in_valid[8] = 1'b1; in_data[8] = 32'(k);
         #1;
         chk($sformatf("fill%0d_in_ready", k), 8, 32'(in_ready[8]), (k <= 4) ? 32'd1 : 32'd0);
         if (in_ready[8]) acc++;
         @(negedge clk);
      end
      in_valid[8] = 1'b0;
      #1;
      chk("fill_accepted", 8, 32'(acc), 32'd4);
      chk("fill_count", 8, 32'(cnt[8]), 32'd4);
      chk("fill_in_ready", 8, 32'(in_ready[8]), 32'd0);
      out_ready[8] = 1'b1;
      got = 0;
      for (int t = 0; t < 12; t++) begin
         if (t > 0) #1;
         if (out_valid[8]) begin
            chk("drain_data", 8, out_data[8], 32'(got + 1));
            got++;
         end
         @(negedge clk);
      end
      chk("drain_total", 8, 32'(got), 32'd4);
      out_ready[8] = 1'b0;

      // DEPTH=1 pass-through: one transfer per cycle.
      pushes = 0; pops = 0;
      in_valid[4] = 1'b1; out_ready[4] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data[4] = 32'(i);
         #1;
         chk("pass_in_ready", 4, 32'(in_ready[4]), 32'd1);
         if (i > 0) begin
            chk("pass_out_valid", 4, 32'(out_valid[4]), 32'd1);
            chk("pass_out_data", 4, out_data[4], 32'(i - 1));
         end
         if (in_ready[4]) pushes++;
         if (out_valid[4]) pops++;
         @(negedge clk);
      end
      in_valid[4] = 1'b0;
      #1;
      chk("pass_last_data", 4, out_data[4], 32'd7);
      if (out_valid[4]) pops++;
      @(negedge clk);
      #1;
      chk("pass_empty", 4, 32'(out_valid[4]), 32'd0);
      chk("pass_pushes", 4, 32'(pushes), 32'd8);
      chk("pass_pops", 4, 32'(pops), 32'd8);
      out_ready[4] = 1'b0;

      // DEPTH=3: wrap pointers twice, fill, flush, then a fresh word emerges first.
      in_valid[2] = 1'b1; out_ready[2] = 1'b1;
      for (int k = 0; k < 7; k++) begin
         in_data[2] = 32'(k);
         @(negedge clk);
      end
      in_valid[2] = 1'b0;
      @(negedge clk);
      out_ready[2] = 1'b0; in_valid[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data[2] = 32'h100 + 32'(k);
         @(negedge clk);
      end
      in_valid[2] = 1'b0;
      #1;
      chk("wrap_count", 2, 32'(cnt[2]), 32'd3);
      chk("wrap_head", 2, out_data[2], 32'h100);
      flush[2] = 1'b1;
      #1;
      chk("flush_out_valid", 2, 32'(out_valid[2]), 32'd0);
      chk("flush_in_ready", 2, 32'(in_ready[2]), 32'd0);
      @(negedge clk);
      flush[2] = 1'b0;
      #1;
      chk("after_flush_count", 2, 32'(cnt[2]), 32'd0);
      chk("after_flush_valid", 2, 32'(out_valid[2]), 32'd0);
      in_valid[2] = 1'b1; in_data[2] = 32'h55;
      @(negedge clk); in_valid[2] = 1'b0;
      #1;
      chk("after_flush_data", 2, out_data[2], 32'h55);
      chk("after_flush_cnt1", 2, 32'(cnt[2]), 32'd1);

      // Random traffic on configs 0..7 against a queue model.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NC; c++) begin
         mq[c].delete();
         prev_stall[c] = 1'b0;
         prev_head[c] = '0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < 8; c++) begin
            flush[c]     = ($urandom_range(63) == 0);
            in_valid[c]  = 1'($urandom_range(1));
            out_ready[c] = 1'($urandom_range(1));
            in_data[c]   = $urandom;
         end
         #1;
         for (int c = 0; c < 8; c++) begin
            int  d, sz;
            bit  e_ir, e_ov;
            d  = cfg_depth(c);
            sz = mq[c].size();
            e_ir = ((sz < d) || (cfg_pass(c) == 1 && out_ready[c])) && !flush[c];
            e_ov = (sz > 0) && !flush[c];
            chk("rnd_in_ready", c, 32'(in_ready[c]), 32'(e_ir));
            chk("rnd_out_valid", c, 32'(out_valid[c]), 32'(e_ov));
            chk("rnd_count", c, 32'(cnt[c]), 32'(sz));
            if (cnt[c] > 4'(d)) chk("rnd_count_bound", c, 32'(cnt[c]), 32'(d));
            if (e_ov) chk("rnd_out_data", c, out_data[c], mq[c][0]);
            if (e_ov && prev_stall[c]) chk("rnd_stall_hold", c, out_data[c], prev_head[c]);
            if (flush[c]) begin
               mq[c].delete();
            end else begin
               if (e_ov && out_ready[c]) void'(mq[c].pop_front());
               if (e_ir && in_valid[c]) mq[c].push_back(in_data[c]);
            end
            prev_stall[c] = e_ov && !out_ready[c];
            prev_head[c]  = e_ov ? out_data[c] : '0;
            if (e_ov) prev_head[c] = (e_ov && out_ready[c]) ? '0 : prev_head[c];
         end
      end
      for (int c = 0; c < 8; c++) begin
         flush[c] = 1'b0; in_valid[c] = 1'b0; out_ready[c] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/elastic_buffer.md
ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of storage entries (>=1).
REQ-003 SHALL have parameter PASS_READY, default 0, 1 = in_ready also asserted when full and out_ready high (comb path out_ready->in_ready); 0 = in_ready depends on registered state only.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  upstream payload.
REQ-008 SHALL have port in_valid  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready  output  1  buffer accepts payload this cycle.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  oldest stored payload.
REQ-011 SHALL have port out_valid  output  1  out_data holds a stored entry.
REQ-012 SHALL have port out_ready  input  1  downstream accepts payload.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  current number of stored entries.

Function
REQ-014 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready, evaluated in the same cycle.
REQ-015 SHALL store entries in FIFO order; out_data SHALL be the oldest entry and come directly from storage (no comb path in_data->out_data).
REQ-016 SHALL present a pushed entry at out_valid no earlier than the cycle after the push edge (latency 1 cycle when empty).
REQ-017 SHALL assert out_valid iff count > 0 and flush is low.
REQ-018 PASS_READY=0: in_ready SHALL equal (count < DEPTH) && !flush.
REQ-019 PASS_READY=1: in_ready SHALL equal ((count < DEPTH) || out_ready) && !flush.
REQ-020 SHALL update count by +1 on push-only, -1 on pop-only, unchanged on push+pop.
REQ-021 SHALL implement read/write pointers of width $clog2(DEPTH) (1 bit min) that wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-022 Simultaneous push and pop when full (PASS_READY=1) SHALL replace the oldest slot's successor correctly: count stays DEPTH, no loss or duplication.
REQ-023 SHALL keep out_data and out_valid stable while out_valid && !out_ready.
REQ-024 flush high SHALL force count, both pointers to 0 at the next edge; push and pop SHALL not occur in a flush cycle.
REQ-025 Flow SHALL sustain 1 transfer/cycle when DEPTH>=2 or PASS_READY=1; DEPTH=1 with PASS_READY=0 SHALL sustain 1 transfer per 2 cycles.
REQ-026 Storage contents SHALL not be required to reset; no output SHALL be X-dependent on unwritten storage while out_valid is low except out_data.

Reset
REQ-027 rst_n low SHALL asynchronously clear count, read pointer, write pointer to 0.
REQ-028 During and after reset: out_valid=0, count=0, in_ready=1 (flush low).
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first post-reset push SHALL be the first popped.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the pointer/count width helper function and default DATA_WIDTH/DEPTH constants.
REQ-031 Storage array SHALL be a sub-module elastic_buffer_mem (DEPTH x DATA_WIDTH, 1 write port, 1 async read port, no reset).
REQ-032 Control (pointers, count, ready/valid) SHALL reside in elastic_buffer; no other sub-modules.

Verification
REQ-033 Reset release, DEPTH=2: push 0xA5A5_0001 cycle 0 -> out_valid=1, out_data=0xA5A5_0001 cycle 1, count=1.
REQ-034 DEPTH=4, out_ready=0, push 5 words -> 4 accepted, in_ready=0 after 4th, count=4; then out_ready=1 -> words 1..4 in order, none duplicated.
REQ-035 DEPTH=1, PASS_READY=1, in_valid and out_ready held 1 for 8 cycles with data 0..7 -> 8 transfers, out_data sequence 0..7 one per cycle after first.
REQ-036 DEPTH=3, count=3 with pointers wrapped twice, flush pulse 1 cycle -> next cycle count=0, out_valid=0; next push 0x55 emerges first.
REQ-037 Random in_valid/out_ready (50%) 10,000 cycles, DEPTH 1/2/3/5 x PASS_READY 0/1 -> scoreboard order exact, count never > DEPTH, out_data stable under stall.
REQ-038 rst_n asserted asynchronously with count=2 -> out_valid=0 and count=0 before next clock edge.
